led_pattern_streamer: RTL

- Parametrised successor to the static colour/pixel lookup used by the NeoPixel controller.
- Generates pixel-load commands ({pixel index, 8-bit colour}) from counters, one per transfer, instead of driving fixed flat arrays.
- Streams commands to the downstream pixel encoder over a valid/ready handshake.
- Supports two pattern modes, programmable frame lengths, a latched hue palette and per-frame hue rotation (animation).

---
 rtl/led_pattern_streamer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/led_pattern_streamer.sv
// Counter-driven pixel-load command generator (rainbow / neon patterns) with a valid/ready output.
// Optional auto-repeat with idle gap between frames: define LED_PATTERN_AUTO_REPEAT_EN.
module led_pattern_streamer #(
    parameter int NUM_PIXELS = 5,
    parameter int PIX_W      = 3,
    parameter int COLOR_W    = 8,
    parameter int NUM_HUES   = 4,
    parameter int HUE_W      = 2,
    parameter int LEN_SHORT  = 15,
    parameter int LEN_MID    = 31,
    parameter int LEN_LONG   = 63,
    parameter int LOAD_W     = 7,
    parameter int GAP_CYCLES = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        sel_rainbow,
    input  logic                        long_mode,
    input  logic                        animate,
    input  logic [NUM_HUES*COLOR_W-1:0] palette,
`ifdef LED_PATTERN_AUTO_REPEAT_EN
    input  logic                        run,
`endif
    output logic                        load_valid,
    input  logic                        load_ready,
    output logic [PIX_W-1:0]            load_pixel,
    output logic [COLOR_W-1:0]          load_color,
    output logic [LOAD_W-1:0]           load_index,
    output logic                        frame_done,
    output logic                        busy,
    output logic [1:0]                  state_dbg
);

    // Handshake: a command transfers on every rising edge where load_valid && load_ready;
    // while load_valid && !load_ready the load_* outputs are held unchanged.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(NUM_PIXELS - 1);
    localparam logic [HUE_W-1:0]  HUE_LAST   = HUE_W'(NUM_HUES - 1);
    localparam logic [LOAD_W-1:0] LAST_SHORT = LOAD_W'(LEN_SHORT - 1);
    localparam logic [LOAD_W-1:0] LAST_MID   = LOAD_W'(LEN_MID - 1);
    localparam logic [LOAD_W-1:0] LAST_LONG  = LOAD_W'(LEN_LONG - 1);

    state_t                      state, state_n;
    logic                        launch, restart, xfer;
    logic                        rainbow_q, animate_q;
    logic [LOAD_W-1:0]           len_last;
    logic [NUM_HUES*COLOR_W-1:0] pal_q;
    logic [PIX_W-1:0]            pix_cnt;
    logic [HUE_W-1:0]            hue_cnt, offset;
    logic                        hue_dn;
    logic [1:0]                  sub_cnt;
    logic [LOAD_W-1:0]           idx_cnt;
    logic [HUE_W:0]              hue_sum;
    logic [HUE_W-1:0]            hue_sel;

`ifdef LED_PATTERN_AUTO_REPEAT_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_cnt;
    logic             relaunch;

    always_ff @(posedge clock) begin
        if (!reset || state != S_GAP) gap_cnt <= '0;
        else                          gap_cnt <= gap_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        launch  = 1'b0;
        xfer    = (state == S_LOAD) && load_ready;
`ifdef LED_PATTERN_AUTO_REPEAT_EN
        relaunch = 1'b0;
`endif
        case (state)
            S_IDLE: if (start) begin
                state_n = S_LOAD;
                launch  = 1'b1;
            end
            // Abort wins over completion, so a last transfer in the abort cycle raises no frame_done.
            S_LOAD: begin
                if (abort)                         state_n = S_IDLE;
                else if (xfer && idx_cnt == len_last) state_n = S_DONE;
            end
`ifdef LED_PATTERN_AUTO_REPEAT_EN
            S_DONE: state_n = run ? S_GAP : S_IDLE;
            S_GAP: begin
                if (!run) state_n = S_IDLE;
                else if (gap_cnt == GAP_LAST) begin
                    state_n  = S_LOAD;
                    relaunch = 1'b1;
                end
            end
`else
            S_DONE: state_n = S_IDLE;
`endif
            default: state_n = S_IDLE;
        endcase
`ifdef LED_PATTERN_AUTO_REPEAT_EN
        restart = launch | relaunch;
`else
        restart = launch;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rainbow_q <= 1'b0;
            animate_q <= 1'b0;
            len_last  <= '0;
            pal_q     <= '0;
            pix_cnt   <= '0;
            hue_cnt   <= '0;
            hue_dn    <= 1'b0;
            sub_cnt   <= '0;
            idx_cnt   <= '0;
            offset    <= '0;
        end else begin
            if (launch) begin
                rainbow_q <= sel_rainbow;
                animate_q <= animate;
                len_last  <= sel_rainbow ? (long_mode ? LAST_LONG : LAST_SHORT) : LAST_MID;
            end
            if (restart) begin
                pal_q   <= palette;
                pix_cnt <= '0;
                hue_cnt <= '0;
                hue_dn  <= 1'b0;
                sub_cnt <= '0;
                idx_cnt <= '0;
            end else if (xfer) begin
                idx_cnt <= idx_cnt + 1'b1;
                if (rainbow_q) begin
                    if (pix_cnt == PIX_LAST) begin
                        pix_cnt <= '0;
                        hue_cnt <= (hue_cnt == HUE_LAST) ? '0 : hue_cnt + 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end else begin
                    if (sub_cnt == 2'd2) begin
                        sub_cnt <= '0;
                        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                    // Ping-pong repeats each end value once before turning around.
                    if (!hue_dn) begin
                        if (hue_cnt == HUE_LAST) hue_dn  <= 1'b1;
                        else                     hue_cnt <= hue_cnt + 1'b1;
                    end else begin
                        if (hue_cnt == '0) hue_dn  <= 1'b0;
                        else               hue_cnt <= hue_cnt - 1'b1;
                    end
                end
            end
            if (state == S_LOAD && state_n == S_DONE && animate_q)
                offset <= (offset == HUE_LAST) ? '0 : offset + 1'b1;
        end
    end

    always_comb begin
        hue_sum = {1'b0, hue_cnt} + {1'b0, offset};
        if (hue_sum >= (HUE_W+1)'(NUM_HUES)) hue_sum = hue_sum - (HUE_W+1)'(NUM_HUES);
        hue_sel    = hue_sum[HUE_W-1:0];
        load_color = '0;
        for (int i = 0; i < NUM_HUES; i++) begin
            if (hue_sel == HUE_W'(i)) load_color = pal_q[i*COLOR_W +: COLOR_W];
        end
    end

    always_comb begin
        load_valid = (state == S_LOAD);
        frame_done = (state == S_DONE);
        busy       = (state != S_IDLE);
        load_pixel = pix_cnt;
        load_index = idx_cnt;
        state_dbg  = state;
    end

endmodule
